// File: rtl/wb_result_buffer.sv
// wb_result_buffer: in-order result FIFO between an execution unit and the writeback mux
module wb_result_buffer #(
  parameter int DEPTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      result_valid,
  input  logic [ID_WIDTH-1:0]       result_id,
  input  logic [DATA_WIDTH-1:0]     result_data,
  output logic                      result_ready,
  output logic                      wb_done,
  output logic [ID_WIDTH-1:0]       wb_id,
  output logic [DATA_WIDTH-1:0]     wb_rd,
  input  logic                      wb_ack,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [ID_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  logic push, pop;
  always_comb begin
    result_ready = count != FULL;
    wb_done = count != '0;
    push = result_valid & result_ready;
    pop = wb_ack & wb_done;
    {wb_id, wb_rd} = mem[rptr];
    occupancy = count;
  end
  always_ff @(posedge clk) if (push) mem[wptr] <= {result_id, result_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= push && !pop ? count + (AW+1)'(1) : pop && !push ? count - (AW+1)'(1) : count;
    end
  end
  a_count_max: assert property (@(posedge clk) disable iff (rst) count <= FULL);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
  a_ack_no_done: assert property (@(posedge clk) disable iff (rst) !(wb_ack && !wb_done));
endmodule

// File: tb/tb_wb_result_buffer.sv
// tb_wb_result_buffer: directed and random checks of wb_result_buffer against a queue model
module tb_wb_result_buffer;
  localparam int DEPTH = 4, DW = 32, IW = 3;
  typedef logic [IW+DW-1:0] ent_t;
  logic clk = 0, rst = 1, result_valid = 0, wb_ack = 0;
  logic [IW-1:0] result_id = '0;
  logic [DW-1:0] result_data = '0;
  logic result_ready, wb_done;
  logic [IW-1:0] wb_id;
  logic [DW-1:0] wb_rd;
  logic [$clog2(DEPTH):0] occupancy;
  int errors = 0, checks = 0;
  ent_t q[$];
  always #5 clk = ~clk;
  wb_result_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .result_valid(result_valid), .result_id(result_id),
    .result_data(result_data), .result_ready(result_ready), .wb_done(wb_done),
    .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack), .occupancy(occupancy));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d, input logic a);
    result_valid = v;
    result_id = id;
    result_data = d;
    wb_ack = a;
  endtask
  // advance one edge, update the queue model, then compare all outputs
  task automatic tick();
    bit rdy = q.size() < DEPTH;
    bit dn = q.size() > 0;
    ent_t h;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (wb_ack && dn) void'(q.pop_front());
      if (result_valid && rdy) q.push_back({result_id, result_data});
    end
    #1;
    chk("done", 64'(wb_done), 64'(q.size() > 0));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("ready", 64'(result_ready), 64'(q.size() < DEPTH));
    if (q.size() > 0) begin
      h = q[0];
      chk("id", 64'(wb_id), 64'(h[DW+:IW]));
      chk("rd", 64'(wb_rd), 64'(h[DW-1:0]));
    end
  endtask
  initial begin
    rst = 1;
    tick();
    rst = 0;
    repeat (10) tick();
    chk("t1_done", 64'(wb_done), 64'd0);
    drive(1, 3'd2, 32'hDEADBEEF, 0);
    tick();
    chk("t2_id", 64'(wb_id), 64'd2);
    chk("t2_rd", 64'(wb_rd), 64'hDEADBEEF);
    drive(0, 0, 0, 0);
    repeat (5) tick();
    drive(0, 0, 0, 1);
    tick();
    chk("t2_occ", 64'(occupancy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, IW'(i), $urandom, 0);
      tick();
    end
    chk("t3_occ", 64'(occupancy), 64'd4);
    chk("t3_ready", 64'(result_ready), 64'd0);
    drive(1, 3'd4, $urandom, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", 64'(wb_id), 64'(i));
      drive(0, 0, 0, 1);
      tick();
    end
    chk("t3_empty", 64'(wb_done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, IW'(i), $urandom, 0);
      tick();
    end
    drive(1, 3'd4, 32'h44444444, 1);
    tick();
    chk("t4_occ", 64'(occupancy), 64'd3);
    drive(1, 3'd4, 32'h44444444, 0);
    tick();
    chk("t4_retry", 64'(occupancy), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_order", 64'(wb_id), 64'(i));
      drive(0, 0, 0, 1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, IW'(i), $urandom, 0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      chk("t5_order", 64'(wb_id), 64'(i % 8));
      drive(1, IW'(i + 2), $urandom, 1);
      tick();
      chk("t5_occ", 64'(occupancy), 64'd2);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, IW'(i + 5), $urandom, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_done", 64'(wb_done), 64'd0);
    chk("t6_occ", 64'(occupancy), 64'd0);
    chk("t6_ready", 64'(result_ready), 64'd1);
    drive(1, 3'd6, 32'h12345678, 0);
    tick();
    chk("t6_lat", 64'(wb_rd), 64'h12345678);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), IW'($urandom), $urandom, 1'($urandom) && q.size() > 0);
      rst = $urandom_range(0, 49) == 0;
      tick();
    end
    rst = 0;
    drive(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
